// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel-tick divider, horizontal/vertical position counters,
// video_on decode and latency-matched hsync/vsync for the digit-window masker.
// Build option: define VGA_TIMING_FRAME_CNT_EN to get a free-running 8-bit
// frame counter; without it frame_cnt reads 0 and no counter flops exist.
module vga_timing_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int SYNC_DLY = 2
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_tick,
  output logic [9:0] hcnt,
  output logic [9:0] vcnt,
  output logic       video_on,
  output logic       line_start,
  output logic       frame_start,
  output logic       hsync,
  output logic       vsync,
  output logic [7:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic       SYNC_IDLE = ~SYNC_POL;

  logic [DIV_W-1:0] divCnt;
  logic [9:0]       hcntNext;
  logic [9:0]       vcntNext;
  logic             videoDec;
  logic             hsyncDec;
  logic             vsyncDec;
  logic             hsyncRaw;
  logic             vsyncRaw;

  // Position the counters move to on the next pixel tick (exact-equality wrap).
  always_comb begin
    hcntNext = hcnt + 10'd1;
    vcntNext = vcnt;
    if (hcnt == H_LAST) begin
      hcntNext = 10'd0;
      vcntNext = (vcnt == V_LAST) ? 10'd0 : vcnt + 10'd1;
    end
  end

  // Decode from the next position so the registered flags line up with hcnt/vcnt.
  always_comb begin
    videoDec = (hcntNext < H_VIS) && (vcntNext < V_VIS);
    hsyncDec = ((hcntNext >= HS_FIRST) && (hcntNext <= HS_LAST)) ? SYNC_POL : SYNC_IDLE;
    vsyncDec = ((vcntNext >= VS_FIRST) && (vcntNext <= VS_LAST)) ? SYNC_POL : SYNC_IDLE;
  end

  // Divider, position counters, decoded flags and line/frame pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      divCnt      <= '0;
      pix_tick    <= 1'b0;
      hcnt        <= 10'd0;
      vcnt        <= 10'd0;
      video_on    <= 1'b0;
      hsyncRaw    <= SYNC_IDLE;
      vsyncRaw    <= SYNC_IDLE;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pix_tick    <= (divCnt == DIV_LAST);
      divCnt      <= (divCnt == DIV_LAST) ? '0 : divCnt + 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (pix_tick) begin
        hcnt        <= hcntNext;
        vcnt        <= vcntNext;
        video_on    <= videoDec;
        hsyncRaw    <= hsyncDec;
        vsyncRaw    <= vsyncDec;
        line_start  <= (hcnt == H_LAST);
        frame_start <= (hcnt == H_LAST) && (vcnt == V_LAST);
      end
    end
  end

  generate
    if (SYNC_DLY == 0) begin : gNoDly
      assign hsync = hsyncRaw;
      assign vsync = vsyncRaw;
    end else begin : gDly
      logic [SYNC_DLY-1:0] hPipe;
      logic [SYNC_DLY-1:0] vPipe;

      // Sync delay line advances only on pixel ticks to match pixel-path latency.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          hPipe <= {SYNC_DLY{SYNC_IDLE}};
          vPipe <= {SYNC_DLY{SYNC_IDLE}};
        end else if (pix_tick) begin
          hPipe[0] <= hsyncRaw;
          vPipe[0] <= vsyncRaw;
          for (int i = 1; i < SYNC_DLY; i++) begin
            hPipe[i] <= hPipe[i-1];
            vPipe[i] <= vPipe[i-1];
          end
        end
      end

      assign hsync = hPipe[SYNC_DLY-1];
      assign vsync = vPipe[SYNC_DLY-1];
    end
  endgenerate

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [7:0] frameCntQ;

  // Count frames on the same tick that starts them; 8-bit natural wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frameCntQ <= 8'd0;
    end else if (pix_tick && (hcnt == H_LAST) && (vcnt == V_LAST)) begin
      frameCntQ <= frameCntQ + 8'd1;
    end
  end

  assign frame_cnt = frameCntQ;
`else
  assign frame_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen with a reduced raster so whole frames run quickly.
// Expected outputs come from an arithmetic model indexed by clocks since reset release.
module tb_vga_timing_gen;

  localparam int CLK_DIV  = 3;
  localparam int H_ACTIVE = 16;
  localparam int H_FP     = 3;
  localparam int H_SYNC   = 5;
  localparam int H_BP     = 4;
  localparam int V_ACTIVE = 8;
  localparam int V_FP     = 2;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 3;
  localparam bit SYNC_POL = 1'b0;
  localparam int SYNC_DLY = 2;

  localparam int HT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FT  = HT * VT;
  localparam int HS0 = H_ACTIVE + H_FP;
  localparam int HS1 = HS0 + H_SYNC - 1;
  localparam int VS0 = V_ACTIVE + V_FP;
  localparam int VS1 = VS0 + V_SYNC - 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pix_tick;
  logic [9:0] hcnt;
  logic [9:0] vcnt;
  logic       video_on;
  logic       line_start;
  logic       frame_start;
  logic       hsync;
  logic       vsync;
  logic [7:0] frame_cnt;
  logic [33:0] obs;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  vga_timing_gen #(
    .CLK_DIV(CLK_DIV), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .SYNC_POL(SYNC_POL), .SYNC_DLY(SYNC_DLY)
  ) dut (
    .clk(clk), .rst(rst), .pix_tick(pix_tick), .hcnt(hcnt), .vcnt(vcnt),
    .video_on(video_on), .line_start(line_start), .frame_start(frame_start),
    .hsync(hsync), .vsync(vsync), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  assign obs = {pix_tick, hcnt, vcnt, video_on, line_start, frame_start, hsync, vsync, frame_cnt};

  // Expected outputs c clocks after reset release (c<=0: in reset).
  function automatic logic [33:0] model(input int c);
    int k, p, pd;
    logic pt, vo, ls, fs, hs, vs, pulse;
    logic [9:0] h, v;
    logic [7:0] fc;
    if (c <= 0) return {1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, ~SYNC_POL, ~SYNC_POL, 8'd0};
    k     = (c - 1) / CLK_DIV;
    pt    = (c % CLK_DIV) == 0;
    p     = k % FT;
    h     = 10'(p % HT);
    v     = 10'(p / HT);
    vo    = (k > 0) && (p % HT < H_ACTIVE) && (p / HT < V_ACTIVE);
    pulse = (k > 0) && ((c - 1) % CLK_DIV == 0);
    ls    = pulse && (p % HT == 0);
    fs    = pulse && (p == 0);
    hs    = ~SYNC_POL;
    vs    = ~SYNC_POL;
    if (k >= SYNC_DLY) begin
      pd = (k - SYNC_DLY) % FT;
      if (pd % HT >= HS0 && pd % HT <= HS1) hs = SYNC_POL;
      if (pd / HT >= VS0 && pd / HT <= VS1) vs = SYNC_POL;
    end
`ifdef VGA_TIMING_FRAME_CNT_EN
    fc = 8'((k / FT) % 256);
`else
    fc = 8'd0;
`endif
    return {pt, h, v, vo, ls, fs, hs, vs, fc};
  endfunction

  task automatic test_reset();
    logic [33:0] exp;
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      exp = model(0);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL reset_hold got=%h expected=%h", obs, exp);
      end
    end
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_startup();
    logic [33:0] exp;
    int ticks = 0;
    int firstVideoH = -1;
    repeat (12 * CLK_DIV) begin
      @(negedge clk);
      cyc++;
      exp = model(cyc);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL startup cyc=%0d got=%h expected=%h", cyc, obs, exp);
      end
      if (pix_tick) ticks++;
      if (video_on && firstVideoH < 0) firstVideoH = int'(hcnt);
    end
    checks++;
    if (ticks !== 12) begin
      errors++;
      $display("FAIL startup_tick_rate got=%0d expected=%0d", ticks, 12);
    end
    checks++;
    if (firstVideoH !== 1) begin
      errors++;
      $display("FAIL startup_video_first_h got=%0d expected=%0d", firstVideoH, 1);
    end
  endtask

  task automatic test_line();
    logic [33:0] exp;
    int lines = 0;
    int lastC = 0;
    int budget = 4 * HT * CLK_DIV + 10;
    while (lines < 3 && budget > 0) begin
      @(negedge clk);
      cyc++;
      budget--;
      exp = model(cyc);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL line cyc=%0d got=%h expected=%h", cyc, obs, exp);
      end
      if (line_start) begin
        checks++;
        if (hcnt !== 10'd0) begin
          errors++;
          $display("FAIL line_start_hcnt got=%0d expected=0", hcnt);
        end
        if (lines > 0) begin
          checks++;
          if (cyc - lastC !== HT * CLK_DIV) begin
            errors++;
            $display("FAIL line_period got=%0d expected=%0d", cyc - lastC, HT * CLK_DIV);
          end
        end
        lastC = cyc;
        lines++;
      end
    end
    checks++;
    if (lines !== 3) begin
      errors++;
      $display("FAIL line_timeout got=%0d expected=3", lines);
    end
  endtask

  task automatic test_sync();
    logic [33:0] exp;
    logic prevH = ~SYNC_POL;
    logic prevV = ~SYNC_POL;
    int hTicks = 0;
    int vTicks = 0;
    int hFalls = 0;
    int vFalls = 0;
    repeat (FT * CLK_DIV) begin
      @(negedge clk);
      cyc++;
      exp = model(cyc);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL sync cyc=%0d got=%h expected=%h", cyc, obs, exp);
      end
      if (pix_tick && hsync == SYNC_POL) hTicks++;
      if (pix_tick && vsync == SYNC_POL) vTicks++;
      if (prevH != SYNC_POL && hsync == SYNC_POL) begin
        hFalls++;
        checks++;
        if (hcnt !== 10'(HS0 + SYNC_DLY)) begin
          errors++;
          $display("FAIL hsync_edge_h got=%0d expected=%0d", hcnt, HS0 + SYNC_DLY);
        end
      end
      if (prevV != SYNC_POL && vsync == SYNC_POL) begin
        vFalls++;
        checks++;
        if (vcnt !== 10'(VS0) || hcnt !== 10'(SYNC_DLY)) begin
          errors++;
          $display("FAIL vsync_edge got=v%0d/h%0d expected=v%0d/h%0d", vcnt, hcnt, VS0, SYNC_DLY);
        end
      end
      prevH = hsync;
      prevV = vsync;
    end
    checks++;
    if (hTicks !== H_SYNC * VT || vTicks !== V_SYNC * HT) begin
      errors++;
      $display("FAIL sync_width got=%0d/%0d expected=%0d/%0d", hTicks, vTicks, H_SYNC * VT, V_SYNC * HT);
    end
    checks++;
    if (hFalls !== VT || vFalls !== 1) begin
      errors++;
      $display("FAIL sync_edges got=%0d/%0d expected=%0d/1", hFalls, vFalls, VT);
    end
  endtask

  task automatic test_frame();
    logic [33:0] exp;
    int starts = 0;
    int firstC = 0;
    int budget = 2 * FT * CLK_DIV + 10;
    while (starts < 2 && budget > 0) begin
      @(negedge clk);
      cyc++;
      budget--;
      exp = model(cyc);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL frame cyc=%0d got=%h expected=%h", cyc, obs, exp);
      end
      if (frame_start) begin
        checks++;
        if (hcnt !== 10'd0 || vcnt !== 10'd0 || !line_start) begin
          errors++;
          $display("FAIL frame_start_pos got=h%0d/v%0d/ls%b expected=h0/v0/ls1", hcnt, vcnt, line_start);
        end
        if (starts == 1) begin
          checks++;
          if (cyc - firstC !== FT * CLK_DIV) begin
            errors++;
            $display("FAIL frame_period got=%0d expected=%0d", cyc - firstC, FT * CLK_DIV);
          end
        end
        firstC = cyc;
        starts++;
      end
    end
    checks++;
    if (starts !== 2) begin
      errors++;
      $display("FAIL frame_timeout got=%0d expected=2", starts);
    end
  endtask

  task automatic test_midframe_reset();
    logic [33:0] exp;
    logic [33:0] rstVec;
    bit found = 0;
    int budget = 2 * FT * CLK_DIV + 10;
    rstVec = model(0);
    while (!found && budget > 0) begin
      @(negedge clk);
      cyc++;
      budget--;
      exp = model(cyc);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL midframe_run cyc=%0d got=%h expected=%h", cyc, obs, exp);
      end
      if (hcnt == 10'(HS0 + SYNC_DLY + 1) && vcnt == 10'(VS1)) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL midframe_timeout got=h%0d/v%0d expected=h%0d/v%0d", hcnt, vcnt, HS0 + SYNC_DLY + 1, VS1);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (obs !== rstVec) begin
      errors++;
      $display("FAIL midframe_async got=%h expected=%h", obs, rstVec);
    end
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_random_reset();
    logic [33:0] exp;
    int n;
    int hold;
    repeat (5) begin
      n = $urandom_range(1, 2 * FT * CLK_DIV);
      repeat (n) begin
        @(negedge clk);
        cyc++;
        exp = model(cyc);
        checks++;
        if (obs !== exp) begin
          errors++;
          $display("FAIL random_run cyc=%0d got=%h expected=%h", cyc, obs, exp);
        end
      end
      #($urandom_range(1, 4)) rst = 1'b1;
      #0.5;
      exp = model(0);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL random_async got=%h expected=%h", obs, exp);
      end
      hold = $urandom_range(1, 4);
      repeat (hold) begin
        @(negedge clk);
        checks++;
        if (obs !== exp) begin
          errors++;
          $display("FAIL random_hold got=%h expected=%h", obs, exp);
        end
      end
      rst = 1'b0;
      cyc = 0;
    end
    repeat (2 * HT * CLK_DIV) begin
      @(negedge clk);
      cyc++;
      exp = model(cyc);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL random_tail cyc=%0d got=%h expected=%h", cyc, obs, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_line();
    test_sync();
    test_frame();
    test_midframe_reset();
    test_random_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
